inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter IW, default 9, meaning instruction word width in bits.
REQ-002 SHALL have parameter AW, default 11, meaning address width; depth = 2**AW words.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port LoadStart  input  1  pulse: begin program load at word 0.
REQ-006 SHALL have port LoadValid  input  1  load beat offered.
REQ-007 SHALL have port LoadData  input  IW  instruction word of the beat.
REQ-008 SHALL have port LoadLast  input  1  marks final beat of the program.
REQ-009 SHALL have port LoadReady  output  1  high in LOAD state only.
REQ-010 SHALL have port FetchReq  input  1  fetch request, samples InstAddress.
REQ-011 SHALL have port InstAddress  input  AW  fetch address.
REQ-012 SHALL have port InstOut  output  IW  fetched instruction.
REQ-013 SHALL have port InstValid  output  1  one-cycle pulse, InstOut valid.
REQ-014 SHALL have port Ready  output  1  high in RUN state (program resident).
REQ-015 SHALL have port WordCount  output  AW+1  words written in last/current load.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN.
REQ-017 SHALL move IDLE->LOAD or RUN->LOAD on LoadStart, clearing write pointer and WordCount to 0.
REQ-018 SHALL, in LOAD, write LoadData to mem[ptr] on each cycle with LoadValid && LoadReady, then ptr+1, WordCount+1.
REQ-019 SHALL leave LOAD for RUN on the cycle after an accepted beat with LoadLast=1, or after an accepted beat at ptr = 2**AW-1 (no wrap; further beats not accepted).
REQ-020 SHALL treat LoadStart during LOAD as restart: ptr and WordCount to 0, no write that cycle.
REQ-021 SHALL, in RUN, on FetchReq register mem[InstAddress] into InstOut and pulse InstValid the next cycle (latency 1); back-to-back FetchReq yields one result per cycle.
REQ-022 SHALL ignore FetchReq in IDLE and LOAD (InstValid stays 0).
REQ-023 SHALL give LoadStart priority over FetchReq in the same RUN cycle; that fetch is dropped.
REQ-024 SHALL hold InstOut at its last value when InstValid is 0.
REQ-025 SHALL not reset memory array contents; program survives reset but state returns to IDLE.

Reset
REQ-026 SHALL on Reset_n low, immediately: state IDLE, ptr 0, WordCount 0, InstOut 0, InstValid 0, LoadReady 0, Ready 0.
REQ-027 SHALL abandon any load in progress on reset; words already written remain, WordCount reads 0.

Configuration
REQ-028 SHALL, with INST_LOAD_PARITY_EN defined, add input LoadPar (1, even parity of LoadData) and output ParityErr (1, sticky).
REQ-029 SHALL, with INST_LOAD_PARITY_EN, reject a beat whose ^LoadData != LoadPar: no write, ptr/WordCount unchanged, LoadLast ignored, ParityErr set until next LoadStart or reset.
REQ-030 SHALL, without INST_LOAD_PARITY_EN, omit LoadPar and ParityErr and accept every handshaked beat.

Verification
REQ-031 Load 4 beats 0x001,0x0A5,0x1FF,0x100 (last on 4th), FetchReq addr 2 -> next cycle InstOut=0x1FF, InstValid=1, WordCount=4, Ready=1.
REQ-032 LoadValid toggling 1/0 with 3 beats -> only handshaked beats written, WordCount=3, RUN entered one cycle after LoadLast beat.
REQ-033 FetchReq in IDLE and in LOAD -> InstValid never asserted, InstOut unchanged.
REQ-034 Reset_n low mid-load after 2 beats -> IDLE, WordCount=0, LoadReady=0 without clock edge; after new LoadStart+reload, fetch of addr 0 returns new word.
REQ-035 AW=2: load 5 beats, no LoadLast -> first 4 written, RUN after 4th, 5th not accepted (LoadReady=0), WordCount=4.
REQ-036 With INST_LOAD_PARITY_EN: beat 0x003 with LoadPar=1 -> rejected, ParityErr=1, WordCount unchanged; resend with LoadPar=0 -> accepted, ParityErr stays 1 until LoadStart.

Source files
------------

// File: rtl/inst_mem_loader_if.sv
// Load/fetch bus for inst_mem_loader.
// LoadPar/ParityErr exist only when INST_LOAD_PARITY_EN is defined.
interface inst_mem_loader_if #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 11
);
    logic          LoadStart;
    logic          LoadValid;
    logic [IW-1:0] LoadData;
    logic          LoadLast;
    logic          LoadReady;
    logic          FetchReq;
    logic [AW-1:0] InstAddress;
    logic [IW-1:0] InstOut;
    logic          InstValid;
    logic          Ready;
    logic [AW:0]   WordCount;
`ifdef INST_LOAD_PARITY_EN
    logic          LoadPar;
    logic          ParityErr;
`endif

    modport master (
`ifdef INST_LOAD_PARITY_EN
        output LoadPar,
        input  ParityErr,
`endif
        output LoadStart, LoadValid, LoadData, LoadLast, FetchReq, InstAddress,
        input  LoadReady, InstOut, InstValid, Ready, WordCount
    );

    modport slave (
`ifdef INST_LOAD_PARITY_EN
        input  LoadPar,
        output ParityErr,
`endif
        input  LoadStart, LoadValid, LoadData, LoadLast, FetchReq, InstAddress,
        output LoadReady, InstOut, InstValid, Ready, WordCount
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory with streaming program loader and 1-cycle fetch port.
// Optional beat parity checking is enabled by defining INST_LOAD_PARITY_EN.
module inst_mem_loader #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 11
) (
    input  logic               Clk,
    input  logic               Reset_n,
    inst_mem_loader_if.slave   bus
);
    localparam int unsigned DEPTH = 2**AW;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0]   word_count;
    logic [IW-1:0] inst_out;
    logic          inst_valid;
    logic          load_ready;
    logic          ready;
    logic          par_ok_c;
    logic          beat_c;
    logic          accept_c;

`ifdef INST_LOAD_PARITY_EN
    logic parity_err;
    assign par_ok_c      = ((^bus.LoadData) == bus.LoadPar);
    assign bus.ParityErr = parity_err;
`else
    assign par_ok_c = 1'b1;
`endif

    // A restart in the same cycle wins over any offered beat.
    assign beat_c   = (state == LOAD) && bus.LoadValid && !bus.LoadStart;
    assign accept_c = beat_c && par_ok_c;

    assign bus.LoadReady = load_ready;
    assign bus.Ready     = ready;
    assign bus.InstOut   = inst_out;
    assign bus.InstValid = inst_valid;
    assign bus.WordCount = word_count;

    // Memory array is deliberately not reset so a program survives Reset_n.
    always_ff @(posedge Clk) begin
        if (accept_c) begin
            mem[ptr] <= bus.LoadData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            word_count <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            load_ready <= 1'b0;
            ready      <= 1'b0;
`ifdef INST_LOAD_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            inst_valid <= 1'b0;
            if (bus.LoadStart) begin
                state      <= LOAD;
                ptr        <= '0;
                word_count <= '0;
                load_ready <= 1'b1;
                ready      <= 1'b0;
`ifdef INST_LOAD_PARITY_EN
                parity_err <= 1'b0;
`endif
            end else begin
                case (state)
                    LOAD: begin
                        if (accept_c) begin
                            ptr        <= ptr + AW'(1);
                            word_count <= word_count + (AW+1)'(1);
                            // Stop at the top of memory rather than wrapping.
                            if (bus.LoadLast || (ptr == {AW{1'b1}})) begin
                                state      <= RUN;
                                load_ready <= 1'b0;
                                ready      <= 1'b1;
                            end
                        end
`ifdef INST_LOAD_PARITY_EN
                        else if (beat_c) begin
                            parity_err <= 1'b1;
                        end
`endif
                    end
                    RUN: begin
                        if (bus.FetchReq) begin
                            inst_out   <= mem[bus.InstAddress];
                            inst_valid <= 1'b1;
                        end
                    end
                    IDLE: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (AW=11 main DUT, AW=2 boundary DUT).
module tb_inst_mem_loader;
    logic Clk = 1'b0;
    logic Reset_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    inst_mem_loader_if #(.IW(9), .AW(11)) b ();
    inst_mem_loader_if #(.IW(9), .AW(2))  b2 ();

    inst_mem_loader #(.IW(9), .AW(11)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(b));
    inst_mem_loader #(.IW(9), .AW(2))  dut2 (.Clk(Clk), .Reset_n(Reset_n), .bus(b2));

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic drive(input logic v, input logic [8:0] d, input logic last);
        b.LoadValid = v;
        b.LoadData  = d;
        b.LoadLast  = last;
`ifdef INST_LOAD_PARITY_EN
        b.LoadPar   = ^d;
`endif
    endtask

    task automatic fetch(input logic req, input logic [10:0] a);
        b.FetchReq    = req;
        b.InstAddress = a;
    endtask

    task automatic test_reset();
        b.LoadStart = 1'b0; drive(1'b0, 9'h000, 1'b0); fetch(1'b0, 11'd0);
        b2.LoadStart = 1'b0; b2.LoadValid = 1'b0; b2.LoadData = '0; b2.LoadLast = 1'b0;
        b2.FetchReq = 1'b0; b2.InstAddress = '0;
`ifdef INST_LOAD_PARITY_EN
        b2.LoadPar = 1'b0;
`endif
        #1 Reset_n = 1'b0;
        #2;
        checks++; if (b.LoadReady !== 1'b0) begin errors++; $display("FAIL rst_loadready: got %b expected 0", b.LoadReady); end
        checks++; if (b.Ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", b.Ready); end
        checks++; if (b.InstValid !== 1'b0) begin errors++; $display("FAIL rst_instvalid: got %b expected 0", b.InstValid); end
        checks++; if (b.InstOut !== 9'h000) begin errors++; $display("FAIL rst_instout: got %h expected 000", b.InstOut); end
        checks++; if (b.WordCount !== 12'd0) begin errors++; $display("FAIL rst_wordcount: got %0d expected 0", b.WordCount); end
        checks++; if (b2.Ready !== 1'b0) begin errors++; $display("FAIL rst_ready2: got %b expected 0", b2.Ready); end
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_ignored();
        fetch(1'b1, 11'd0);
        tick();
        checks++; if (b.InstValid !== 1'b0) begin errors++; $display("FAIL idle_fetch_valid: got %b expected 0", b.InstValid); end
        checks++; if (b.InstOut !== 9'h000) begin errors++; $display("FAIL idle_fetch_out: got %h expected 000", b.InstOut); end
        b.LoadStart = 1'b1;
        tick();
        b.LoadStart = 1'b0;
        checks++; if (b.LoadReady !== 1'b1) begin errors++; $display("FAIL enter_load: got %b expected 1", b.LoadReady); end
        fetch(1'b1, 11'd5);
        tick();
        checks++; if (b.InstValid !== 1'b0) begin errors++; $display("FAIL load_fetch_valid: got %b expected 0", b.InstValid); end
        checks++; if (b.InstOut !== 9'h000) begin errors++; $display("FAIL load_fetch_out: got %h expected 000", b.InstOut); end
        fetch(1'b0, 11'd0);
        // restart mid-load
        drive(1'b1, 9'h0AA, 1'b0); tick();
        drive(1'b1, 9'h0BB, 1'b0); tick();
        checks++; if (b.WordCount !== 12'd2) begin errors++; $display("FAIL pre_restart_wc: got %0d expected 2", b.WordCount); end
        b.LoadStart = 1'b1; drive(1'b1, 9'h0CC, 1'b0); tick();
        b.LoadStart = 1'b0; drive(1'b0, 9'h000, 1'b0);
        checks++; if (b.WordCount !== 12'd0) begin errors++; $display("FAIL restart_wc: got %0d expected 0", b.WordCount); end
        checks++; if (b.LoadReady !== 1'b1) begin errors++; $display("FAIL restart_loadready: got %b expected 1", b.LoadReady); end
        // first beat after restart lands at address 0
        drive(1'b1, 9'h0DD, 1'b1); tick();
        drive(1'b0, 9'h000, 1'b0);
        fetch(1'b1, 11'd0); tick();
        fetch(1'b0, 11'd0);
        checks++; if (b.InstOut !== 9'h0DD) begin errors++; $display("FAIL restart_addr0: got %h expected 0dd", b.InstOut); end
    endtask

    task automatic test_basic_load();
        logic [8:0] beats [4];
        beats[0] = 9'h001; beats[1] = 9'h0A5; beats[2] = 9'h1FF; beats[3] = 9'h100;
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, beats[i], (i == 3));
            tick();
            checks++; if (b.WordCount !== 12'(i + 1)) begin errors++; $display("FAIL basic_wc%0d: got %0d expected %0d", i, b.WordCount, i + 1); end
        end
        drive(1'b0, 9'h000, 1'b0);
        checks++; if (b.Ready !== 1'b1 || b.LoadReady !== 1'b0) begin errors++; $display("FAIL basic_run: got ready=%b loadready=%b expected 1/0", b.Ready, b.LoadReady); end
        fetch(1'b1, 11'd2); tick();
        checks++; if (b.InstValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", b.InstValid); end
        checks++; if (b.InstOut !== 9'h1FF) begin errors++; $display("FAIL basic_out: got %h expected 1ff", b.InstOut); end
        checks++; if (b.WordCount !== 12'd4) begin errors++; $display("FAIL basic_wc_final: got %0d expected 4", b.WordCount); end
    endtask

    task automatic test_back_to_back();
        fetch(1'b1, 11'd0); tick();
        checks++; if (b.InstValid !== 1'b1 || b.InstOut !== 9'h001) begin errors++; $display("FAIL b2b_0: got v=%b %h expected 1 001", b.InstValid, b.InstOut); end
        fetch(1'b1, 11'd3); tick();
        checks++; if (b.InstValid !== 1'b1 || b.InstOut !== 9'h100) begin errors++; $display("FAIL b2b_3: got v=%b %h expected 1 100", b.InstValid, b.InstOut); end
        fetch(1'b0, 11'd1); tick();
        checks++; if (b.InstValid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b expected 0", b.InstValid); end
        checks++; if (b.InstOut !== 9'h100) begin errors++; $display("FAIL hold_out: got %h expected 100", b.InstOut); end
    endtask

    task automatic test_valid_gaps();
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        drive(1'b1, 9'h011, 1'b0); tick();
        checks++; if (b.WordCount !== 12'd1) begin errors++; $display("FAIL gap_wc1: got %0d expected 1", b.WordCount); end
        // LoadLast without LoadValid must not end the load
        drive(1'b0, 9'h0EE, 1'b1); tick();
        checks++; if (b.WordCount !== 12'd1 || b.Ready !== 1'b0) begin errors++; $display("FAIL gap_idle: got wc=%0d ready=%b expected 1/0", b.WordCount, b.Ready); end
        drive(1'b1, 9'h022, 1'b0); tick();
        drive(1'b0, 9'h0EE, 1'b0); tick();
        checks++; if (b.WordCount !== 12'd2) begin errors++; $display("FAIL gap_wc2: got %0d expected 2", b.WordCount); end
        drive(1'b1, 9'h033, 1'b1); tick();
        drive(1'b0, 9'h000, 1'b0);
        checks++; if (b.WordCount !== 12'd3 || b.Ready !== 1'b1) begin errors++; $display("FAIL gap_run: got wc=%0d ready=%b expected 3/1", b.WordCount, b.Ready); end
        fetch(1'b1, 11'd1); tick();
        checks++; if (b.InstOut !== 9'h022) begin errors++; $display("FAIL gap_addr1: got %h expected 022", b.InstOut); end
        fetch(1'b1, 11'd2); tick();
        fetch(1'b0, 11'd0);
        checks++; if (b.InstOut !== 9'h033) begin errors++; $display("FAIL gap_addr2: got %h expected 033", b.InstOut); end
    endtask

    task automatic test_start_priority();
        b.LoadStart = 1'b1; fetch(1'b1, 11'd1); tick();
        b.LoadStart = 1'b0; fetch(1'b0, 11'd0);
        checks++; if (b.InstValid !== 1'b0 || b.InstOut !== 9'h033) begin errors++; $display("FAIL prio_fetch: got v=%b %h expected 0 033", b.InstValid, b.InstOut); end
        checks++; if (b.LoadReady !== 1'b1 || b.Ready !== 1'b0) begin errors++; $display("FAIL prio_state: got lr=%b r=%b expected 1/0", b.LoadReady, b.Ready); end
        drive(1'b1, 9'h044, 1'b1); tick();
        drive(1'b0, 9'h000, 1'b0);
        fetch(1'b1, 11'd0); tick();
        fetch(1'b0, 11'd0);
        checks++; if (b.InstOut !== 9'h044 || b.WordCount !== 12'd1) begin errors++; $display("FAIL prio_reload: got %h wc=%0d expected 044 1", b.InstOut, b.WordCount); end
    endtask

    task automatic test_reset_mid_load();
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        drive(1'b1, 9'h0AA, 1'b0); tick();
        drive(1'b1, 9'h055, 1'b0); tick();
        drive(1'b0, 9'h000, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (b.WordCount !== 12'd0) begin errors++; $display("FAIL midrst_wc: got %0d expected 0", b.WordCount); end
        checks++; if (b.LoadReady !== 1'b0 || b.Ready !== 1'b0) begin errors++; $display("FAIL midrst_flags: got lr=%b r=%b expected 0/0", b.LoadReady, b.Ready); end
        tick();
        Reset_n = 1'b1;
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        drive(1'b1, 9'h1C3, 1'b1); tick();
        drive(1'b0, 9'h000, 1'b0);
        fetch(1'b1, 11'd0); tick();
        checks++; if (b.InstOut !== 9'h1C3) begin errors++; $display("FAIL midrst_new: got %h expected 1c3", b.InstOut); end
        // word from the abandoned load survives
        fetch(1'b1, 11'd1); tick();
        fetch(1'b0, 11'd0);
        checks++; if (b.InstOut !== 9'h055) begin errors++; $display("FAIL midrst_old: got %h expected 055", b.InstOut); end
    endtask

    task automatic test_no_wrap();
        b2.LoadStart = 1'b1; tick(); b2.LoadStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b2.LoadValid = 1'b1;
            b2.LoadData  = 9'(9'h101 + i);
            b2.LoadLast  = 1'b0;
`ifdef INST_LOAD_PARITY_EN
            b2.LoadPar   = ^b2.LoadData;
`endif
            tick();
            checks++; if (b2.WordCount !== 3'(i < 4 ? i + 1 : 4)) begin errors++; $display("FAIL wrap_wc%0d: got %0d expected %0d", i, b2.WordCount, (i < 4 ? i + 1 : 4)); end
        end
        b2.LoadValid = 1'b0;
        checks++; if (b2.Ready !== 1'b1 || b2.LoadReady !== 1'b0) begin errors++; $display("FAIL wrap_run: got r=%b lr=%b expected 1/0", b2.Ready, b2.LoadReady); end
        b2.FetchReq = 1'b1; b2.InstAddress = 2'd3; tick();
        checks++; if (b2.InstOut !== 9'h104) begin errors++; $display("FAIL wrap_addr3: got %h expected 104", b2.InstOut); end
        b2.InstAddress = 2'd0; tick();
        b2.FetchReq = 1'b0;
        checks++; if (b2.InstOut !== 9'h101) begin errors++; $display("FAIL wrap_addr0: got %h expected 101", b2.InstOut); end
    endtask

`ifdef INST_LOAD_PARITY_EN
    task automatic test_parity();
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        b.LoadValid = 1'b1; b.LoadData = 9'h003; b.LoadLast = 1'b1; b.LoadPar = 1'b1; tick();
        checks++; if (b.ParityErr !== 1'b1 || b.WordCount !== 12'd0 || b.LoadReady !== 1'b1) begin errors++; $display("FAIL par_reject: got pe=%b wc=%0d lr=%b expected 1 0 1", b.ParityErr, b.WordCount, b.LoadReady); end
        b.LoadPar = 1'b0; tick();
        b.LoadValid = 1'b0; b.LoadLast = 1'b0;
        checks++; if (b.ParityErr !== 1'b1 || b.WordCount !== 12'd1 || b.Ready !== 1'b1) begin errors++; $display("FAIL par_accept: got pe=%b wc=%0d r=%b expected 1 1 1", b.ParityErr, b.WordCount, b.Ready); end
        b.LoadStart = 1'b1; tick(); b.LoadStart = 1'b0;
        checks++; if (b.ParityErr !== 1'b0) begin errors++; $display("FAIL par_clear: got %b expected 0", b.ParityErr); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_ignored();
        test_basic_load();
        test_back_to_back();
        test_valid_gaps();
        test_start_priority();
        test_reset_mid_load();
        test_no_wrap();
`ifdef INST_LOAD_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
